zclk_phase: RTL and testbench

Consumer of the 28 MHz strobe set (f0/f1, h0/h1, c0..c3) produced by the core clock generator. It checks that the strobes rotate correctly and acquires lock. It then derives the Z80 clock-edge strobes `zpos`/`zneg` for the selected turbo rate, switching rate only at a phase-safe point. It sits between the clock generator and the CPU/memory arbiter and is the single source of CPU clock enables.

---
 rtl/zclk_phase_if.sv | 30 +++
 rtl/zclk_phase.sv | 158 +++++++++++++++
 tb/tb_zclk_phase.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/zclk_phase_if.sv
// Strobe/clock-enable bundle between the clock generator, zclk_phase and the CPU side.
// master drives the strobe set and requests; slave (zclk_phase) returns the CPU edges and status.
interface zclk_phase_if;
    logic       f0;
    logic       f1;
    logic       h0;
    logic       h1;
    logic       c0;
    logic       c1;
    logic       c2;
    logic       c3;
    logic [1:0] turbo_req;
    logic       stall;
    logic       zpos;
    logic       zneg;
    logic [1:0] turbo_cur;
    logic       lock;
    logic       fault;
    logic [7:0] fault_cnt;

    modport master (
        output f0, f1, h0, h1, c0, c1, c2, c3, turbo_req, stall,
        input  zpos, zneg, turbo_cur, lock, fault, fault_cnt
    );

    modport slave (
        input  f0, f1, h0, h1, c0, c1, c2, c3, turbo_req, stall,
        output zpos, zneg, turbo_cur, lock, fault, fault_cnt
    );
endinterface

// File: rtl/zclk_phase.sv
// Verifies the 28 MHz strobe rotation, acquires lock and issues Z80 zpos/zneg enables.
// Optional saturating fault counter built only when ZCLK_FAULT_CNT_EN is defined.
//
// state     | meaning
// ST_ACQ    | counting consecutive consistent cycles, no CPU edges
// ST_LOCKED | strobe set trusted, CPU edges issued, inconsistency faults
module zclk_phase #(
    parameter int ACQ_LEN = 8
) (
    input  logic         clk,
    input  logic         rst,
    zclk_phase_if.slave  bus
);
    localparam logic [0:0] ST_ACQ    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;
    localparam logic [3:0] ACQ_TC    = 4'(ACQ_LEN);

    logic [3:0] c;
    logic       hist_vld_q;
    logic [3:0] c_prev_q;
    logic       f0_prev_q, f1_prev_q, h0_prev_q;
    logic [0:0] state_q, state_d;
    logic [3:0] acq_cnt_q, acq_cnt_d;
    logic       q3_q, q3_d;
    logic       level_q, level_d;
    logic [1:0] turbo_q, turbo_d;
    logic       zpos_q, zneg_q, fault_q;

    logic onehot, rot_ok, f_ok, h_ok, consistent;
    logic good, bad, locked, run;
    logic pos_cand, neg_cand, issue_pos, issue_neg, do_switch;

    assign c = {bus.c3, bus.c2, bus.c1, bus.c0};

    assign onehot     = (c != 4'd0) && ((c & (c - 4'd1)) == 4'd0);
    assign rot_ok     = (c == {c_prev_q[2:0], c_prev_q[3]});
    assign f_ok       = (bus.f0 == ~f0_prev_q) && (bus.f1 == ~bus.f0);
    assign h_ok       = (bus.h1 == ~bus.h0) &&
                        (bus.h0 == (f1_prev_q ? ~h0_prev_q : h0_prev_q));
    assign consistent = onehot & rot_ok & f_ok & h_ok;

    // The first cycle after reset only primes history, so it is neither good nor bad.
    assign good   = hist_vld_q & consistent;
    assign bad    = hist_vld_q & ~consistent;
    assign locked = (state_q == ST_LOCKED);
    assign run    = locked & good;

    always_comb begin
        pos_cand = 1'b0;
        neg_cand = 1'b0;
        case (turbo_q)
            2'b00: begin
                pos_cand = bus.c0 & ~q3_q;
                neg_cand = bus.c0 & q3_q;
            end
            2'b01: begin
                pos_cand = bus.c0;
                neg_cand = bus.c2;
            end
            default: begin
                pos_cand = bus.c0 | bus.c2;
                neg_cand = bus.c1 | bus.c3;
            end
        endcase
    end

    assign issue_pos = run & pos_cand & ~level_q & ~bus.stall;
    assign issue_neg = run & neg_cand & level_q;
    assign do_switch = run & bus.c0 & ~q3_q & ~level_q;

    always_comb begin
        state_d   = state_q;
        acq_cnt_d = acq_cnt_q;
        q3_d      = q3_q;
        level_d   = level_q;
        turbo_d   = turbo_q;
        if (!locked) begin
            q3_d    = 1'b0;
            level_d = 1'b0;
            if (good) begin
                if (acq_cnt_q + 4'd1 == ACQ_TC) begin
                    state_d   = ST_LOCKED;
                    acq_cnt_d = 4'd0;
                end else begin
                    acq_cnt_d = acq_cnt_q + 4'd1;
                end
            end else if (bad) begin
                acq_cnt_d = 4'd0;
            end
        end else if (bad) begin
            state_d   = ST_ACQ;
            acq_cnt_d = 4'd0;
            q3_d      = 1'b0;
            level_d   = 1'b0;
        end else if (good) begin
            if (bus.c0)
                q3_d = ~q3_q;
            if (issue_pos)
                level_d = 1'b1;
            else if (issue_neg)
                level_d = 1'b0;
            if (do_switch)
                turbo_d = bus.turbo_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_vld_q <= 1'b0;
            c_prev_q   <= 4'd0;
            f0_prev_q  <= 1'b0;
            f1_prev_q  <= 1'b0;
            h0_prev_q  <= 1'b0;
            state_q    <= ST_ACQ;
            acq_cnt_q  <= 4'd0;
            q3_q       <= 1'b0;
            level_q    <= 1'b0;
            turbo_q    <= 2'b00;
            zpos_q     <= 1'b0;
            zneg_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            hist_vld_q <= 1'b1;
            c_prev_q   <= c;
            f0_prev_q  <= bus.f0;
            f1_prev_q  <= bus.f1;
            h0_prev_q  <= bus.h0;
            state_q    <= state_d;
            acq_cnt_q  <= acq_cnt_d;
            q3_q       <= q3_d;
            level_q    <= level_d;
            turbo_q    <= turbo_d;
            zpos_q     <= issue_pos;
            zneg_q     <= issue_neg;
            fault_q    <= locked & bad;
        end
    end

    assign bus.zpos      = zpos_q;
    assign bus.zneg      = zneg_q;
    assign bus.turbo_cur = turbo_q;
    assign bus.lock      = locked;
    assign bus.fault     = fault_q;

`ifdef ZCLK_FAULT_CNT_EN
    // Counts alongside the fault pulse so fault_cnt and fault change on the same edge.
    logic [7:0] fault_cnt_q;
    always_ff @(posedge clk) begin
        if (rst)
            fault_cnt_q <= 8'd0;
        else if (locked && bad && fault_cnt_q != 8'hFF)
            fault_cnt_q <= fault_cnt_q + 8'd1;
    end
    assign bus.fault_cnt = fault_cnt_q;
`else
    assign bus.fault_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_zclk_phase.sv
// Randomized bench for zclk_phase: legal strobe stream with injected corruption,
// random stall/turbo/reset, compared each cycle against a behavioural model.
module tb_zclk_phase;
    localparam int ACQ_LEN = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    zclk_phase_if bus ();

    zclk_phase #(.ACQ_LEN(ACQ_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int unsigned t     = 0;
    bit          cur_stall = 1'b0;
    bit [1:0]    cur_treq  = 2'b00;

    // behavioural model state
    bit       m_hist, m_locked, m_q3, m_level;
    int       m_acq, m_fcnt;
    bit [3:0] m_cprev;
    bit       m_f0p, m_f1p, m_h0p;
    bit [1:0] m_turbo;
    bit       e_zpos, e_zneg, e_fault;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int oh_index(input bit [3:0] v);
        int idx = -1;
        for (int i = 0; i < 4; i++)
            if (v[i]) idx = i;
        return idx;
    endfunction

    function automatic bit m_consistent(input bit [3:0] c, input bit f0, input bit f1,
                                        input bit h0, input bit h1);
        if ($countones(c) != 1 || $countones(m_cprev) != 1) return 1'b0;
        if (oh_index(c) != (oh_index(m_cprev) + 1) % 4) return 1'b0;
        if (f0 == m_f0p || f1 == f0) return 1'b0;
        if (h1 == h0) return 1'b0;
        if (h0 != (m_f1p ? !m_h0p : m_h0p)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit r, input bit [3:0] c, input bit f0, input bit f1,
                              input bit h0, input bit h1, input bit st, input bit [1:0] tr);
        bit cons, pos, neg;
        int idx;
        e_zpos  = 1'b0;
        e_zneg  = 1'b0;
        e_fault = 1'b0;
        if (r) begin
            m_hist = 0; m_locked = 0; m_acq = 0; m_q3 = 0; m_level = 0;
            m_turbo = 2'b00; m_fcnt = 0;
        end else begin
            if (m_hist) begin
                cons = m_consistent(c, f0, f1, h0, h1);
                if (!m_locked) begin
                    if (cons) begin
                        m_acq++;
                        if (m_acq == ACQ_LEN) begin
                            m_locked = 1;
                            m_acq    = 0;
                        end
                    end else begin
                        m_acq = 0;
                    end
                end else if (!cons) begin
                    e_fault  = 1;
                    m_locked = 0; m_acq = 0; m_q3 = 0; m_level = 0;
                    if (m_fcnt < 255) m_fcnt++;
                end else begin
                    idx = oh_index(c);
                    case (m_turbo)
                        2'd0:    begin pos = (idx == 0) && !m_q3; neg = (idx == 0) && m_q3; end
                        2'd1:    begin pos = (idx == 0);          neg = (idx == 2);         end
                        default: begin pos = (idx % 2 == 0);      neg = (idx % 2 == 1);     end
                    endcase
                    e_zpos = pos && !m_level && !st;
                    e_zneg = neg && m_level;
                    if (idx == 0 && !m_q3 && !m_level) m_turbo = tr;
                    if (e_zpos) m_level = 1;
                    if (e_zneg) m_level = 0;
                    if (idx == 0) m_q3 = !m_q3;
                end
            end
            m_hist  = 1;
            m_cprev = c;
            m_f0p   = f0;
            m_f1p   = f1;
            m_h0p   = h0;
        end
    endtask

    // corrupt: 0 none, 1 c=0011, 2 flip f0, 3 h1=h0, 4 c=0, 5 c skips a phase
    task automatic apply(input bit do_rst, input int corrupt);
        bit [3:0] c;
        bit f0, f1, h0, h1;
        c  = 4'(1 << (t % 4));
        f0 = (t % 2) == 1;
        f1 = !f0;
        h0 = (((t + 1) / 2) % 2) == 1;
        h1 = !h0;
        case (corrupt)
            1: c  = 4'b0011;
            2: f0 = !f0;
            3: h1 = h0;
            4: c  = 4'b0000;
            5: c  = 4'(1 << ((t + 2) % 4));
            default: ;
        endcase
        rst           = do_rst;
        bus.c0        = c[0];
        bus.c1        = c[1];
        bus.c2        = c[2];
        bus.c3        = c[3];
        bus.f0        = f0;
        bus.f1        = f1;
        bus.h0        = h0;
        bus.h1        = h1;
        bus.stall     = cur_stall;
        bus.turbo_req = cur_treq;
        model_step(do_rst, c, f0, f1, h0, h1, cur_stall, cur_treq);
        t++;
    endtask

    task automatic compare_all();
        int exp_cnt;
`ifdef ZCLK_FAULT_CNT_EN
        exp_cnt = m_fcnt;
`else
        exp_cnt = 0;
`endif
        check("zpos",      {7'd0, bus.zpos},      {7'd0, e_zpos});
        check("zneg",      {7'd0, bus.zneg},      {7'd0, e_zneg});
        check("fault",     {7'd0, bus.fault},     {7'd0, e_fault});
        check("lock",      {7'd0, bus.lock},      {7'd0, m_locked});
        check("turbo_cur", {6'd0, bus.turbo_cur}, {6'd0, m_turbo});
        check("fault_cnt", bus.fault_cnt,         8'(exp_cnt));
    endtask

    task automatic tick(input bit do_rst, input int corrupt);
        @(negedge clk);
        compare_all();
        apply(do_rst, corrupt);
    endtask

    initial begin
        int lat;
        bit seen;
        apply(1'b1, 0);
        tick(1'b1, 0);
        tick(1'b1, 0);

        // lock latency from a clean stream with no strobes before lock
        cur_treq = 2'b01;
        lat = 255;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 0);
            if (bus.lock) begin
                lat = i;
                break;
            end
        end
        check("lock_lat", 8'(lat), 8'(ACQ_LEN + 1));

        repeat (40) tick(1'b0, 0);

        // 00 then switch to 1x mid-stream
        cur_treq = 2'b00;
        repeat (40) tick(1'b0, 0);
        cur_treq = 2'b10;
        repeat (40) tick(1'b0, 0);

        // stall across several candidates in 1x
        cur_stall = 1'b1;
        repeat (5) tick(1'b0, 0);
        cur_stall = 1'b0;
        repeat (10) tick(1'b0, 0);

        // single c=0011 corruption while locked, then relock
        tick(1'b0, 1);
        repeat (30) tick(1'b0, 0);

        // random stall / turbo / corruption / reset
        for (int i = 0; i < 2000; i++) begin
            int corrupt;
            if (i % 16 == 0) cur_treq = 2'($urandom_range(0, 3));
            cur_stall = ($urandom_range(0, 3) == 0);
            corrupt   = ($urandom_range(0, 49) == 0) ? int'($urandom_range(1, 5)) : 0;
            tick(($urandom_range(0, 299) == 0), corrupt);
        end

        // reset one cycle after a zpos
        cur_stall = 1'b0;
        cur_treq  = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1'b0, 0);
            if (bus.zpos) begin
                seen = 1'b1;
                break;
            end
        end
        check("zpos_seen", {7'd0, seen}, 8'd1);
        tick(1'b1, 0);
        repeat (4) tick(1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
